// File: rtl/rca_arb_pkg.sv
// Shared defaults and helpers for the RCA round-robin arbiter slice.
package rca_arb_pkg;

    localparam int unsigned C_WIDTH_DEF = 8;
    localparam int unsigned N_REQ_DEF   = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rca_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_pick
    import rca_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned ID_W  = id_width(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    output logic             any_grant_o,
    output logic [ID_W-1:0]  grant_o
);

    logic [2*N_REQ-1:0] dbl;
    int unsigned        last;

    // Doubling the vector turns the wrap-around search into a linear scan
    // over the window (last, last+N_REQ].
    always_comb begin
        dbl         = {req_i, req_i};
        last        = int'(last_grant_i);
        any_grant_o = 1'b0;
        grant_o     = '0;
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            if (!any_grant_o && (i > last) && (i <= last + N_REQ) && dbl[i]) begin
                any_grant_o = 1'b1;
                grant_o     = ID_W'(i % N_REQ);
            end
        end
    end

endmodule

// File: rtl/rca_rr_arbiter.sv
// Round-robin front end sharing one external ripple-carry adder among N_REQ requesters.
module rca_rr_arbiter
    import rca_arb_pkg::*;
#(
    parameter  int unsigned C_WIDTH = C_WIDTH_DEF,
    parameter  int unsigned N_REQ   = N_REQ_DEF,
    localparam int unsigned ID_W    = id_width(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*C_WIDTH-1:0] req_a,
    input  logic [N_REQ*C_WIDTH-1:0] req_b,
    output logic [C_WIDTH-1:0]       add_a,
    output logic [C_WIDTH-1:0]       add_b,
    input  logic [C_WIDTH:0]         add_sum,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [C_WIDTH:0]         rsp_sum
);

    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [C_WIDTH:0] rsp_sum_q;
    logic [ID_W-1:0] last_grant_q;

    logic            any_req;
    logic [ID_W-1:0] grant_idx;
    logic            can_accept;
    logic            grant_en;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .any_grant_o  (any_req),
        .grant_o      (grant_idx)
    );

    // rstn gates the grant so the adder inputs and readies are quiet in reset.
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign grant_en   = rstn && can_accept && any_req;

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        if (grant_en) begin
            req_ready[grant_idx] = 1'b1;
            add_a = req_a[int'(grant_idx)*C_WIDTH +: C_WIDTH];
            add_b = req_b[int'(grant_idx)*C_WIDTH +: C_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else if (grant_en) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant_idx;
            rsp_sum_q    <= add_sum;
            last_grant_q <= grant_idx;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_rca_rr_arbiter.sv
// Directed bench for rca_rr_arbiter with a behavioural adder on add_a/add_b/add_sum.
module tb_rca_rr_arbiter;

    localparam int unsigned CW = 8;
    localparam int unsigned NR = 4;

    logic             clk;
    logic             rstn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*CW-1:0] req_a;
    logic [NR*CW-1:0] req_b;
    logic [CW-1:0]    add_a;
    logic [CW-1:0]    add_b;
    logic [CW:0]      add_sum;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [CW:0]      rsp_sum;

    int n_cmp;
    int n_err;

    // Operand table and hand-computed 9-bit sums per requester.
    logic [CW-1:0] opa  [NR] = '{8'h11, 8'h22, 8'h33, 8'hF4};
    logic [CW-1:0] opb  [NR] = '{8'h01, 8'h02, 8'h03, 8'h10};
    logic [CW:0]   osum [NR] = '{9'h012, 9'h024, 9'h036, 9'h104};

    rca_rr_arbiter #(
        .C_WIDTH (CW),
        .N_REQ   (NR)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_table();
        for (int i = 0; i < NR; i++) begin
            req_a[i*CW +: CW] = opa[i];
            req_b[i*CW +: CW] = opb[i];
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        load_table();
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        load_table();
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_cmp++; if (add_a !== 8'h00) begin n_err++; $display("FAIL reset_add_a got=%h exp=00", add_a); end
        n_cmp++; if (add_b !== 8'h00) begin n_err++; $display("FAIL reset_add_b got=%h exp=00", add_b); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (rsp_sum !== 9'h000) begin n_err++; $display("FAIL reset_rsp_sum got=%h exp=000", rsp_sum); end
        next_cycle();
        req_valid = '0;
        rstn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_a[0 +: CW] = 8'h0F;
        req_b[0 +: CW] = 8'h01;
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        n_cmp++; if (add_a !== 8'h0F) begin n_err++; $display("FAIL single_add_a got=%h exp=0f", add_a); end
        n_cmp++; if (add_b !== 8'h01) begin n_err++; $display("FAIL single_add_b got=%h exp=01", add_b); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (rsp_sum !== 9'h010) begin n_err++; $display("FAIL single_rsp_sum got=%h exp=010", rsp_sum); end
        n_cmp++; if (add_a !== 8'h00) begin n_err++; $display("FAIL idle_add_a got=%h exp=00", add_a); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_sum !== 9'h010) begin n_err++; $display("FAIL drain_hold_sum got=%h exp=010", rsp_sum); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL drain_hold_id got=%0d exp=0", rsp_id); end
    endtask

    task automatic test_round_robin();
        int exp_g [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== (4'b0001 << exp_g[k])) begin
                n_err++; $display("FAIL rr_ready[%0d] got=%b exp_idx=%0d", k, req_ready, exp_g[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_g[k-1]) || rsp_sum !== osum[exp_g[k-1]]) begin
                    n_err++;
                    $display("FAIL rr_rsp[%0d] got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                             k, rsp_valid, rsp_id, rsp_sum, exp_g[k-1], osum[exp_g[k-1]]);
                end
            end
            next_cycle();
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_overflow();
        do_reset();
        req_a[2*CW +: CW] = 8'hFF;
        req_b[2*CW +: CW] = 8'hFF;
        req_valid = 4'b0100;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL ovf_ready got=%b exp=0100", req_ready); end
        next_cycle();
        req_a[2*CW +: CW] = 8'h80;
        req_b[2*CW +: CW] = 8'h80;
        @(negedge clk);
        n_cmp++; if (rsp_sum !== 9'h1FE) begin n_err++; $display("FAIL ovf_sum_ff got=%h exp=1fe", rsp_sum); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL ovf_id got=%0d exp=2", rsp_id); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL ovf_ready2 got=%b exp=0100", req_ready); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rsp_sum !== 9'h100) begin n_err++; $display("FAIL ovf_sum_80 got=%h exp=100", rsp_sum); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b1111;
        next_cycle();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== osum[0]) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b id=%0d sum=%h exp rdy=0000 v=1 id=0 sum=%h",
                         k, req_ready, rsp_valid, rsp_id, rsp_sum, osum[0]);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_release_rsp got v=%b id=%0d exp v=1 id=0", rsp_valid, rsp_id); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== osum[1]) begin
            n_err++; $display("FAIL bp_update got v=%b id=%0d sum=%h exp v=1 id=1 sum=%h", rsp_valid, rsp_id, rsp_sum, osum[1]);
        end
        next_cycle();
    endtask

    task automatic test_rotation_skip();
        do_reset();
        req_valid = 4'b0010;
        next_cycle();
        req_valid = 4'b1001;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL skip_grant3 got=%b exp=1000", req_ready); end
        next_cycle();
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL skip_grant0 got=%b exp=0001", req_ready); end
        n_cmp++; if (rsp_id !== 2'd3 || rsp_sum !== osum[3]) begin n_err++; $display("FAIL skip_rsp3 got id=%0d sum=%h exp id=3 sum=%h", rsp_id, rsp_sum, osum[3]); end
        next_cycle();
        req_valid = 4'b0010;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL skip_grant1 got=%b exp=0010", req_ready); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL skip_rsp0 got id=%0d exp=0", rsp_id); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL skip_rsp1 got id=%0d exp=1", rsp_id); end
        next_cycle();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        req_valid = 4'b1111;
        next_cycle();
        req_valid = 4'b1111;
        rstn = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_ready got=%b exp=0000", req_ready); end
        next_cycle();
        rstn = 1'b1;
        req_valid = 4'b0011;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_first got=%b exp=0001", req_ready); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_err++; $display("FAIL midrst_rsp got v=%b id=%0d exp v=1 id=0", rsp_valid, rsp_id); end
        next_cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_rotation_skip();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rca_rr_arbiter.md
Name: rca_rr_arbiter

Overview:
Round-robin controller that shares one combinational ripple-carry adder (RCA, C_WIDTH-bit operands, C_WIDTH+1-bit sum) among N_REQ requesters.
- Accepts at most one request per cycle over valid/ready handshakes.
- Drives the shared adder's operand ports from the granted requester.
- Captures the sum into a single-entry response register, tagged with the requester id.
- Sits between operand producers and the RCA instance; the RCA instance is external and is wired to add_a/add_b/add_sum at the parent level.

Parameters:
C_WIDTH, 8, operand width; sum width is C_WIDTH+1.
N_REQ, 4, number of requesters (>=2).
ID_W, $clog2(N_REQ), derived localparam; width of rsp_id.

Ports:
clk  in  1  clock.
rstn  in  1  reset, asynchronous, active-low.
req_valid  in  N_REQ  per-requester request valid.
req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
req_a  in  N_REQ*C_WIDTH  flattened operand A; requester i at [i*C_WIDTH +: C_WIDTH].
req_b  in  N_REQ*C_WIDTH  flattened operand B; same packing as req_a.
add_a  out  C_WIDTH  operand A to the shared RCA.
add_b  out  C_WIDTH  operand B to the shared RCA.
add_sum  in  C_WIDTH+1  result from the shared RCA (combinational from add_a/add_b).
rsp_valid  out  1  response register holds a result.
rsp_ready  in  1  consumer accepts the response.
rsp_id  out  ID_W  index of the requester that produced the response.
rsp_sum  out  C_WIDTH+1  captured sum; bit C_WIDTH is the carry-out.

Behaviour:
- Reset (rstn low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_sum=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has highest priority after reset.
  - While rstn is low: req_ready=0, add_a=0, add_b=0.
- Slot free: can_accept = !rsp_valid || rsp_ready.
- Grant, combinational, same cycle:
  - If can_accept and any req_valid, grant g = first valid index searching last_grant+1, last_grant+2, ... modulo N_REQ.
  - req_ready[g]=1; all other req_ready bits are 0.
  - add_a=req_a[g], add_b=req_b[g].
  - With no grant: req_ready=0, add_a=0, add_b=0.
- Capture on the clock edge with a grant:
  - rsp_sum<=add_sum, rsp_id<=g, rsp_valid<=1, last_grant<=g.
  - Latency is one cycle from handshake to rsp_valid. Throughput is one result per cycle when rsp_ready is held high.
- Drain: if rsp_valid && rsp_ready and there is no grant, rsp_valid<=0; rsp_id and rsp_sum hold their last values.
- Simultaneous drain and grant: the new result overwrites the register; rsp_valid stays 1.
- Backpressure: while rsp_valid && !rsp_ready:
  - all req_ready=0;
  - rsp_valid, rsp_id and rsp_sum are held stable;
  - last_grant is unchanged.
- Requester rules:
  - Once req_valid[i] is asserted, it must stay high, with req_a/req_b stable, until req_ready[i].
  - The block does not check this rule.
  - A requester that drops valid before being granted is simply skipped.
- Width: no truncation anywhere. The carry-out is preserved in rsp_sum[C_WIDTH].
- Fairness: a continuously valid requester is granted within N_REQ accepted transactions.
- Reset mid-operation: a pending response is discarded immediately; priority restarts at requester 0.
- No FSM beyond the rsp_valid bit and the last_grant pointer. No other state.

Decomposition:
- Package rca_arb_pkg: C_WIDTH/N_REQ defaults and an id-width function (clog2 with a minimum of 1).
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: any_grant, grant index.
  - Uses double-width masked priority encoding.
  - Reusable by other arbiters in the team's blocks.

Test Plan:
Configuration for all scenarios: C_WIDTH=8, N_REQ=4; the RCA instance is connected to add_a/add_b/add_sum.
- After reset, only req0 valid with a=0x0F, b=0x01 -> req_ready[0]=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x010.
- All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one cycle later; no idle cycles.
- Overflow: req2 with a=0xFF, b=0xFF -> rsp_sum=0x1FE, rsp_id=2. Also a=0x80, b=0x80 -> rsp_sum=0x100.
- Backpressure:
  - rsp_ready=0 for 5 cycles with all requesters valid -> req_ready=0 and rsp_* stable throughout.
  - Raise rsp_ready -> a new grant and req_ready in that same cycle, rsp_valid stays 1, and the register updates on the next edge.
- Rotation skip: last_grant=1 and only req3 and req0 valid -> grant 3, then 0; req1 becoming valid afterwards -> granted next.
- Reset mid-stream: drop rstn while rsp_valid=1 -> rsp_valid=0 asynchronously. After release with req1 and req0 valid -> req0 is granted first.
